// File: rtl/hazard_unit_if.sv
// Decode-side connection of the hazard unit: the instruction in IF/ID, its
// redirect request, and the stall / flush / gated redirect returned to the pipe.
interface hazard_unit_if;
  logic [31:0] instrCode_IF;
  logic        instrValid_IF;
  logic        PC_SrcMuxSel;
  logic        stall;
  logic        flush_IF;
  logic        PC_SrcMuxSel_HZ;

  // Pipeline / decode side: presents the instruction, consumes the controls.
  modport master (
    output instrCode_IF,
    output instrValid_IF,
    output PC_SrcMuxSel,
    input  stall,
    input  flush_IF,
    input  PC_SrcMuxSel_HZ
  );

  // Hazard unit side.
  modport slave (
    input  instrCode_IF,
    input  instrValid_IF,
    input  PC_SrcMuxSel,
    output stall,
    output flush_IF,
    output PC_SrcMuxSel_HZ
  );
endinterface

// File: rtl/hazard_unit.sv
// Stall / flush controller for the 5-stage RV32I core without forwarding.
// A three-entry shadow scoreboard follows destination registers through
// ID/EX, EX/MEM and MEM/WB; any read of an in-flight rd stalls decode.
module hazard_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  hazard_unit_if.slave     hz,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount,
  output logic             hazardError
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic       writes_rd, reads_rs1, reads_rs2;
  logic       hit_rs1, hit_rs2;
  logic       stall_int, redirect_hz;

  // Scoreboard entries, oldest last.
  logic       sb_ex_valid, sb_mem_valid, sb_wb_valid;
  logic [4:0] sb_ex_rd, sb_mem_rd, sb_wb_rd;

  logic [1:0] run_cnt;

  // funct3/funct7/immediate bits play no part in hazard detection.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{hz.instrCode_IF[31:25], hz.instrCode_IF[14:12]};

  assign opcode = hz.instrCode_IF[6:0];
  assign rd     = hz.instrCode_IF[11:7];
  assign rs1    = hz.instrCode_IF[19:15];
  assign rs2    = hz.instrCode_IF[24:20];

  // Opcode decode into read/write usage; x0 never counts as either.
  always_comb begin
    writes_rd = 1'b0;
    reads_rs1 = 1'b0;
    reads_rs2 = 1'b0;
    case (opcode)
      OP_R:      begin writes_rd = 1'b1; reads_rs1 = 1'b1; reads_rs2 = 1'b1; end
      OP_I_ALU:  begin writes_rd = 1'b1; reads_rs1 = 1'b1; end
      OP_LOAD:   begin writes_rd = 1'b1; reads_rs1 = 1'b1; end
      OP_LUI:    writes_rd = 1'b1;
      OP_AUIPC:  writes_rd = 1'b1;
      OP_JAL:    writes_rd = 1'b1;
      OP_JALR:   begin writes_rd = 1'b1; reads_rs1 = 1'b1; end
      OP_STORE:  begin reads_rs1 = 1'b1; reads_rs2 = 1'b1; end
      OP_BRANCH: begin reads_rs1 = 1'b1; reads_rs2 = 1'b1; end
      default:   ;
    endcase
    if (rd == 5'd0)  writes_rd = 1'b0;
    if (rs1 == 5'd0) reads_rs1 = 1'b0;
    if (rs2 == 5'd0) reads_rs2 = 1'b0;
  end

  // Source-operand match against every in-flight writer, WB included since
  // the register file is written on that same edge.
  always_comb begin
    hit_rs1 = reads_rs1 &&
              ((sb_ex_valid  && sb_ex_rd  == rs1) ||
               (sb_mem_valid && sb_mem_rd == rs1) ||
               (sb_wb_valid  && sb_wb_rd  == rs1));
    hit_rs2 = reads_rs2 &&
              ((sb_ex_valid  && sb_ex_rd  == rs2) ||
               (sb_mem_valid && sb_mem_rd == rs2) ||
               (sb_wb_valid  && sb_wb_rd  == rs2));
  end

  // Stall outranks redirect: a branch still waiting on operands must not
  // steer the PC until the cycle its operands are clean.
  assign stall_int   = hz.instrValid_IF & (hit_rs1 | hit_rs2);
  assign redirect_hz = hz.PC_SrcMuxSel & hz.instrValid_IF & ~stall_int;

  assign hz.stall           = stall_int;
  assign hz.PC_SrcMuxSel_HZ = redirect_hz;
  assign hz.flush_IF        = redirect_hz;

  // Scoreboard shift; a stalled or bubble slot enters ID/EX as an invalid entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_ex_valid  <= 1'b0;
      sb_mem_valid <= 1'b0;
      sb_wb_valid  <= 1'b0;
      sb_ex_rd     <= 5'd0;
      sb_mem_rd    <= 5'd0;
      sb_wb_rd     <= 5'd0;
    end else begin
      sb_wb_valid  <= sb_mem_valid;
      sb_wb_rd     <= sb_mem_rd;
      sb_mem_valid <= sb_ex_valid;
      sb_mem_rd    <= sb_ex_rd;
      sb_ex_valid  <= hz.instrValid_IF & ~stall_int & writes_rd;
      sb_ex_rd     <= rd;
    end
  end

  // Free-running performance counters, wrapping at 2^CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (stall_int)   stallCount <= stallCount + CNT_W'(1);
      if (redirect_hz) flushCount <= flushCount + CNT_W'(1);
    end
  end

  // Watchdog: a stall run longer than the 3-cycle pipeline drain is a bug.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_cnt     <= 2'd0;
      hazardError <= 1'b0;
    end else if (stall_int) begin
      if (run_cnt == 2'd3) hazardError <= 1'b1;
      else                 run_cnt     <= run_cnt + 2'd1;
    end else begin
      run_cnt <= 2'd0;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: reset, RAW stall timing, redirect gating,
// counters and asynchronous reset during a stall.
module tb_hazard_unit;
  localparam int CNT_W = 32;

  logic             clk;
  logic             reset;
  logic [CNT_W-1:0] stallCount, flushCount;
  logic             hazardError;

  hazard_unit_if hif();

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .hz          (hif),
    .stallCount  (stallCount),
    .flushCount  (flushCount),
    .hazardError (hazardError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        valid;
    logic        sel;
    logic        exp_stall;
    logic        exp_flush;
    logic [31:0] exp_scnt;
    logic [31:0] exp_fcnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string n, input logic [31:0] i, input logic v,
                              input logic s, input logic es, input logic ef,
                              input logic [31:0] sc, input logic [31:0] fc);
    vec_t t;
    t.name = n; t.instr = i; t.valid = v; t.sel = s;
    t.exp_stall = es; t.exp_flush = ef; t.exp_scnt = sc; t.exp_fcnt = fc;
    vecs.push_back(t);
  endfunction

  task automatic drive(input logic [31:0] i, input logic v, input logic s);
    hif.instrCode_IF  = i;
    hif.instrValid_IF = v;
    hif.PC_SrcMuxSel  = s;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Table starts with x6 in ID/EX, stallCount=3, flushCount=0.
    add("bubble_redir",  32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 3, 0);
    add("bubble1",       32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0);
    add("bubble2",       32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0);
    add("addi_x0",       32'h0010_0013, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0);
    add("add_x0_x0",     32'h0000_0033, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0);
    add("addi_x5",       32'h0010_0293, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0);
    add("addi_x6_indep", 32'h0010_0313, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0);
    add("drain1",        32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0);
    add("drain2",        32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0);
    add("drain3",        32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0);
    add("beq_clean",     32'h0000_0063, 1'b1, 1'b1, 1'b0, 1'b1, 3, 0);
    add("lw_x7",         32'h0000_2383, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1);
    add("nop_bubble",    32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1);
    add("beq_x7_wait1",  32'h0003_8063, 1'b1, 1'b1, 1'b1, 1'b0, 3, 1);
    add("beq_x7_wait2",  32'h0003_8063, 1'b1, 1'b1, 1'b1, 1'b0, 4, 1);
    add("beq_x7_go",     32'h0003_8063, 1'b1, 1'b1, 1'b0, 1'b1, 5, 1);
    add("after_branch",  32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 5, 2);

    // Reset held two cycles with a reader of x5 presented.
    reset = 1'b1;
    drive(32'h0052_8333, 1'b1, 1'b0);
    next_cycle();
    check("rst_stall", {31'd0, hif.stall}, 32'd0);
    check("rst_flush", {31'd0, hif.flush_IF}, 32'd0);
    hif.PC_SrcMuxSel = 1'b1;
    #1;
    check("rst_hz_pass", {31'd0, hif.PC_SrcMuxSel_HZ}, 32'd1);
    next_cycle();
    check("rst_scnt", stallCount, 32'd0);
    check("rst_fcnt", flushCount, 32'd0);
    check("rst_err", {31'd0, hazardError}, 32'd0);
    hif.PC_SrcMuxSel = 1'b0;
    reset = 1'b0;

    // Back-to-back RAW: addi x5 then add x6,x5,x5.
    drive(32'h0010_0293, 1'b1, 1'b0);
    @(negedge clk);
    check("raw_producer", {31'd0, hif.stall}, 32'd0);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      drive(32'h0052_8333, 1'b1, 1'b0);
      @(negedge clk);
      check($sformatf("raw_stall_c%0d", i), {31'd0, hif.stall}, (i < 3) ? 32'd1 : 32'd0);
      next_cycle();
    end
    check("raw_sb_ex_valid", {31'd0, dut.sb_ex_valid}, 32'd1);
    check("raw_sb_ex_rd", {27'd0, dut.sb_ex_rd}, 32'd6);
    check("raw_scnt", stallCount, 32'd3);

    // Vector table.
    foreach (vecs[k]) begin
      drive(vecs[k].instr, vecs[k].valid, vecs[k].sel);
      @(negedge clk);
      check({vecs[k].name, "_stall"}, {31'd0, hif.stall}, {31'd0, vecs[k].exp_stall});
      check({vecs[k].name, "_flush"}, {31'd0, hif.flush_IF}, {31'd0, vecs[k].exp_flush});
      check({vecs[k].name, "_hz"}, {31'd0, hif.PC_SrcMuxSel_HZ}, {31'd0, vecs[k].exp_flush});
      check({vecs[k].name, "_scnt"}, stallCount, vecs[k].exp_scnt);
      check({vecs[k].name, "_fcnt"}, flushCount, vecs[k].exp_fcnt);
      next_cycle();
    end
    check("tbl_end_scnt", stallCount, 32'd5);
    check("tbl_end_fcnt", flushCount, 32'd2);
    check("tbl_end_err", {31'd0, hazardError}, 32'd0);

    // Store rs2 dependency, then asynchronous reset in the second stall cycle.
    drive(32'h0010_0293, 1'b1, 1'b0);
    @(negedge clk);
    check("st_producer", {31'd0, hif.stall}, 32'd0);
    next_cycle();
    drive(32'h0050_2023, 1'b1, 1'b0);
    @(negedge clk);
    check("st_stall1", {31'd0, hif.stall}, 32'd1);
    next_cycle();
    #2;
    check("st_stall2", {31'd0, hif.stall}, 32'd1);
    check("st_scnt_pre", stallCount, 32'd6);
    reset = 1'b1;
    #1;
    check("arst_stall", {31'd0, hif.stall}, 32'd0);
    check("arst_scnt", stallCount, 32'd0);
    check("arst_fcnt", flushCount, 32'd0);
    check("arst_err", {31'd0, hazardError}, 32'd0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_stall", {31'd0, hif.stall}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline sequencing controller for the 5-stage RV32I core. It sits beside the decode stage and watches the instruction held in the IF/ID register. A shadow scoreboard tracks which destination registers are still in flight in ID/EX, EX/MEM and MEM/WB. From this it generates the decode-stage stall, the IF/ID flush on a redirect, and the gated PC source select. The core has no forwarding paths and branches resolve in decode, so every RAW dependency on an in-flight writer is resolved by stalling.

## Interface
Parameters:
- CNT_W, default 32: width of the stall and flush performance counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- instrCode_IF  in  32  instruction currently presented to decode (IF/ID register output).
- instrValid_IF  in  1  1 = instrCode_IF is a real instruction; 0 = bubble.
- PC_SrcMuxSel  in  1  raw redirect request from decode (jal, or taken branch).
- stall  out  1  holds the PC and IF/ID register and inserts a bubble into ID/EX; combinational.
- flush_IF  out  1  clears IF/ID at the next edge; combinational.
- PC_SrcMuxSel_HZ  out  1  gated redirect that drives the PC mux; combinational.
- stallCount  out  CNT_W  cycles with stall=1 since reset; wraps.
- flushCount  out  CNT_W  cycles with flush_IF=1 since reset; wraps.
- hazardError  out  1  sticky flag: stall held for more than 3 consecutive cycles.

## Operation
- **Decode of instrCode_IF (opcode [6:0]):**
  - Writes rd: R 0110011, I-ALU 0010011, LOAD 0000011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
  - Reads rs1 [19:15]: R, I-ALU, LOAD, STORE 0100011, BRANCH 1100011, JALR.
  - Reads rs2 [24:20]: R, STORE, BRANCH only.
  - Any other opcode neither reads nor writes.
  - rd=x0 never counts as a write; rs=x0 never counts as a read.
- **Scoreboard:** three entries, sb_EX, sb_MEM and sb_WB, each {valid, rd[4:0]}. Every edge:
  - sb_WB <= sb_MEM
  - sb_MEM <= sb_EX
  - sb_EX <= (instrValid_IF & ~stall & writesRd) ? {1, rd} : {0, x}
- **Hazard:** stall = instrValid_IF & (hitRs1 | hitRs2). hitRsN is 1 when rsN is read and nonzero and equals the rd of any valid entry.
  - The WB entry counts as a hit: the register file writes at the WB edge and the read is combinational, so decode would read the old value.
- **Redirect:**
  - PC_SrcMuxSel_HZ = PC_SrcMuxSel & instrValid_IF & ~stall.
  - flush_IF = PC_SrcMuxSel_HZ.
  - A branch waiting on its operands never redirects. It redirects in the first cycle its operands are clean.
- **Counters:**
  - stallCount increments in every cycle with stall=1.
  - flushCount increments in every cycle with flush_IF=1.
  - Both wrap modulo 2^CNT_W.
- **Watchdog:** a 2-bit saturating run counter increments while stall=1 and clears when stall=0. stall=1 in a cycle where the run counter already equals 3 sets hazardError. hazardError clears only on reset.

## Timing
- **Reset values:**
  - All scoreboard entries invalid.
  - stallCount=0, flushCount=0, hazardError=0, run counter 0.
  - With the scoreboard empty, stall=0, flush_IF=0, and PC_SrcMuxSel_HZ follows PC_SrcMuxSel & instrValid_IF.
- **Stall latency:**
  - A consumer immediately after its producer stalls 3 cycles.
  - A consumer 2 behind its producer stalls 2 cycles; 3 behind stalls 1 cycle; 4 or more behind stalls 0 cycles.
- stall, flush_IF and PC_SrcMuxSel_HZ are purely combinational from inputs and state, with zero-cycle latency. Counters and scoreboard are registered with one-cycle latency.
- Loads need no special case: in-order 5-stage timing with no forwarding gives the same 3-cycle worst case.
- **Stall and redirect in the same cycle:** stall wins. The redirect is masked, no flush occurs, and the request is re-evaluated next cycle.
- **Bubble input (instrValid_IF=0):** stall=0, no redirect, and a bubble enters sb_EX.
- **Reset asserted mid-stall:** the scoreboard clears immediately, so stall drops to 0 in the same cycle, asynchronously.

## Test plan
- **Reset:** hold reset 2 cycles with instrValid_IF=1 and instrCode_IF=0x00528333 (add x6,x5,x5) -> stall=0, stallCount=0, flushCount=0, hazardError=0.
- **Back-to-back RAW:** present 0x00100293 (addi x5,x0,1), then hold 0x00528333 -> stall=1 for exactly 3 cycles, then 0. stallCount=3, and sb_EX holds rd=6 on the cycle after release.
- **No hazard:**
  - 0x00100013 (addi x0,x0,1) followed by 0x00000033 (add x0,x0,x0) -> stall never asserts.
  - 0x00100293 followed by 0x00100313 (addi x6,x0,1) -> stall never asserts.
- **Taken branch, clean operands:** PC_SrcMuxSel=1 for one cycle, scoreboard empty -> PC_SrcMuxSel_HZ=1 and flush_IF=1 for that cycle, flushCount=1.
- **Branch behind a load:**
  - Sequence: lw x7,0(x0) (0x00002383), then a nop bubble, then beq x7,x0 with PC_SrcMuxSel=1 held.
  - Required: stall=1 for 2 cycles with PC_SrcMuxSel_HZ=0 and flush_IF=0, then PC_SrcMuxSel_HZ=1 and flush_IF=1 in the third cycle.
- **Store rs2 dependency and async reset:**
  - addi x5 (0x00100293) followed by sw x5,0(x0) (0x00502023) -> stall=1.
  - Assert reset asynchronously during the 2nd stall cycle -> stall falls without waiting for a clock edge, and all counters read 0.
